// File: rtl/apb_master_fsm.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_fsm
// Description : APB requester. Runs single commands through SETUP/ACCESS and
//               returns one response pulse, with a wait-state timeout guard.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_fsm #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] PRDATA
);

  localparam int c_WCNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int c_WAIT_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [c_WCNT_W-1:0] c_WAIT_LAST = c_WAIT_LAST_I[c_WCNT_W-1:0];
  localparam logic [c_WCNT_W-1:0] c_WCNT_MAX  = {c_WCNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_WCNT_W-1:0] r_wait_cnt;
  logic                w_accept;
  logic                w_done;
  logic                w_timeout;

  assign PSELx    = (r_state != S_IDLE);
  assign PENABLE  = (r_state == S_ACCESS);
  assign w_accept = cmd_valid & cmd_ready;

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        // Accepting during completion lets a queued command skip IDLE.
        cmd_ready = PREADY;
        if (PREADY) begin
          w_done      = 1'b1;
          w_state_nxt = cmd_valid ? S_SETUP : S_IDLE;
        end else if ((TIMEOUT > 0) && (r_wait_cnt == c_WAIT_LAST)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      rsp_valid <= w_done | w_timeout;

      if (w_accept) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end

      // Saturating count so a disabled timeout never wraps.
      if (w_state_nxt == S_SETUP) begin
        r_wait_cnt <= '0;
      end else if ((r_state == S_ACCESS) && !PREADY && (r_wait_cnt != c_WCNT_MAX)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      if (w_done) begin
        rsp_err     <= PSLVERR;
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_timeout <= 1'b0;
      end else if (w_timeout) begin
        rsp_err     <= 1'b1;
        rsp_rdata   <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_fsm
// Description : Directed self-checking bench for apb_master_fsm (TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_fsm;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [63:0] PWDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [63:0] PRDATA;

  int checks = 0;
  int errors = 0;

  apb_master_fsm #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; sample point is 1ns after the rising edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [63:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    tick(); tick();
    checks++;
    if ({PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b exp 000000", {PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout});
    end
    checks++;
    if ({PADDR, PWDATA, rsp_rdata} !== 160'h0) begin
      errors++;
      $display("FAIL reset_data: paddr %h pwdata %h rdata %h exp 0", PADDR, PWDATA, rsp_rdata);
    end
    PRESET = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: got %b exp 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    issue(1'b1, 32'h10, 64'hDEAD_BEEF_0000_0001);
    PREADY = 1'b1;
    checks++;
    if ({cmd_ready, PSELx} !== 2'b10) begin
      errors++; $display("FAIL wr_c0: ready/psel %b exp 10", {cmd_ready, PSELx});
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({PSELx, PENABLE, PWRITE, cmd_ready} !== 4'b1010 || PADDR !== 32'h10 || PWDATA !== 64'hDEAD_BEEF_0000_0001) begin
      errors++;
      $display("FAIL wr_setup: ctrl %b addr %h data %h exp 1010 10 deadbeef00000001",
               {PSELx, PENABLE, PWRITE, cmd_ready}, PADDR, PWDATA);
    end
    tick();
    checks++;
    if ({PSELx, PENABLE, cmd_ready, rsp_valid} !== 4'b1110) begin
      errors++; $display("FAIL wr_access: got %b exp 1110", {PSELx, PENABLE, cmd_ready, rsp_valid});
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, PSELx} !== 4'b1000 || rsp_rdata !== 64'h0) begin
      errors++;
      $display("FAIL wr_rsp: flags %b rdata %h exp 1000 0", {rsp_valid, rsp_err, rsp_timeout, PSELx}, rsp_rdata);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL wr_pulse: rsp_valid %b exp 0", rsp_valid);
    end
  endtask

  task automatic test_read_wait();
    issue(1'b0, 32'h18, 64'h0BAD);
    PREADY = 1'b0;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (PADDR !== 32'h18 || PSELx !== 1'b1 || PENABLE !== (c >= 2) || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL rd_wait_c%0d: addr %h sel %b en %b rv %b rdy %b", c, PADDR, PSELx, PENABLE, rsp_valid, cmd_ready);
      end
      if (c == 5) begin
        PREADY = 1'b1;
        PRDATA = 64'h1234;
      end
      tick();
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 64'h1234) begin
      errors++;
      $display("FAIL rd_wait_rsp: flags %b rdata %h exp 100 1234", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
    end
  endtask

  task automatic test_slverr();
    issue(1'b0, 32'h50, 64'h0);
    PREADY = 1'b0; PSLVERR = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 64'h77;
    tick();
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 64'h77) begin
      errors++;
      $display("FAIL err_ignored: valid/err %b rdata %h exp 10 77", {rsp_valid, rsp_err}, rsp_rdata);
    end
    issue(1'b0, 32'h58, 64'h0);
    PSLVERR = 1'b1; PRDATA = 64'hABCD;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110 || rsp_rdata !== 64'hABCD) begin
      errors++;
      $display("FAIL err_rsp: flags %b rdata %h exp 110 abcd", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
    end
    PSLVERR = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 32'h20, 64'h2020);
    PREADY = 1'b1;
    tick();
    issue(1'b0, 32'h28, 64'h0);
    checks++;
    if ({PSELx, PENABLE, cmd_ready} !== 3'b100) begin
      errors++; $display("FAIL b2b_setup1: got %b exp 100", {PSELx, PENABLE, cmd_ready});
    end
    tick();
    checks++;
    if ({PSELx, PENABLE, PWRITE, cmd_ready} !== 4'b1111 || PADDR !== 32'h20) begin
      errors++;
      $display("FAIL b2b_access1: ctrl %b addr %h exp 1111 20", {PSELx, PENABLE, PWRITE, cmd_ready}, PADDR);
    end
    tick();
    cmd_valid = 1'b0;
    PRDATA = 64'h5555;
    checks++;
    if ({PSELx, PENABLE, PWRITE, rsp_valid, rsp_err} !== 5'b10010 || PADDR !== 32'h28 || rsp_rdata !== 64'h0) begin
      errors++;
      $display("FAIL b2b_setup2: ctrl %b addr %h rdata %h exp 10010 28 0",
               {PSELx, PENABLE, PWRITE, rsp_valid, rsp_err}, PADDR, rsp_rdata);
    end
    tick();
    checks++;
    if ({PSELx, PENABLE, rsp_valid} !== 3'b110) begin
      errors++; $display("FAIL b2b_access2: got %b exp 110", {PSELx, PENABLE, rsp_valid});
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_err, PSELx} !== 3'b100 || rsp_rdata !== 64'h5555) begin
      errors++;
      $display("FAIL b2b_rsp2: flags %b rdata %h exp 100 5555", {rsp_valid, rsp_err, PSELx}, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'h40, 64'h0);
    PREADY = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (PENABLE !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: PENABLE %b exp 1", PENABLE);
    end
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    PREADY = 1'b1;
    checks++;
    if ({PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 6'b0 ||
        {PADDR, PWDATA, rsp_rdata} !== 160'h0) begin
      errors++;
      $display("FAIL rst_mid_outs: ctrl %b addr %h rdata %h exp all 0",
               {PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}, PADDR, rsp_rdata);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({rsp_valid, PSELx} !== 2'b00) begin
        errors++; $display("FAIL rst_mid_norsp%0d: valid/sel %b exp 00", c, {rsp_valid, PSELx});
      end
    end
  endtask

  task automatic test_timeout();
    issue(1'b0, 32'h30, 64'h0);
    PREADY = 1'b0; PRDATA = 64'hFFFF;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int c = 2; c <= 5; c++) begin
      checks++;
      if ({PSELx, PENABLE, rsp_valid, cmd_ready} !== 4'b1100) begin
        errors++;
        $display("FAIL to_wait_c%0d: got %b exp 1100", c, {PSELx, PENABLE, rsp_valid, cmd_ready});
      end
      tick();
    end
    checks++;
    if ({PSELx, rsp_valid, rsp_err, rsp_timeout} !== 4'b0111 || rsp_rdata !== 64'h0) begin
      errors++;
      $display("FAIL to_rsp: flags %b rdata %h exp 0111 0", {PSELx, rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
    end
    issue(1'b1, 32'h38, 64'h3838);
    PREADY = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL to_next_ready: got %b exp 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 64'h0) begin
      errors++;
      $display("FAIL to_next_rsp: flags %b rdata %h exp 100 0", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
